// File: rtl/rshift_deser_rx.sv
// rshift_deser_rx: serial-to-parallel receiver with a one-entry valid/ready
// holding register, sticky overrun flag and optional even-parity check.
// Optional feature: define PARITY_CHECK_EN to add a trailing parity bit per
// frame (PAR state) and a sticky parity_err flag; otherwise parity_err is 0.
//
// Output handshake: data_out/data_valid form a valid/ready source. A word
// transfers on any posedge where data_valid & data_ready; data_out is held
// stable while data_valid=1 and no transfer occurs, and data_valid never
// drops without a transfer. data_ready while data_valid=0 is ignored.
module rshift_deser_rx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overrun,
  input  logic             overrun_clr,
  output logic             parity_err,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_next;
  logic [WIDTH-1:0] word;
  logic             complete;
  logic             accept;
  logic             transfer;
  logic             data_bit;

  // A plain data bit (not a frame restart) arriving while a frame is open.
  assign data_bit = sin_valid && !frame_start;

  // Shift order selects which end of the word the first bit lands in.
  always_comb begin
    sreg_next = sreg;
    if (MSB_FIRST) sreg_next = {sreg[WIDTH-2:0], sin};
    else           sreg_next = {sin, sreg[WIDTH-1:1]};
  end

`ifdef PARITY_CHECK_EN
  logic par_bad;
  // Frame completes on the parity bit; the data word is already in sreg.
  assign complete = data_bit && (state == PAR);
  assign word     = sreg;
  assign par_bad  = (^sreg) != sin;
`else
  // Frame completes on the last data bit; the word includes that bit.
  assign complete = data_bit && (state == SHIFT) && (cnt == LAST_IDX);
  assign word     = sreg_next;
`endif

  assign transfer  = data_valid && data_ready;
  assign accept    = complete && (!data_valid || data_ready);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Frame FSM: bit collection, restart on frame_start, gaps hold state.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
      sreg  <= '0;
    end else if (sin_valid) begin
      if (frame_start) begin
        // Start (or restart) a frame: this bit is bit 1.
        sreg  <= sreg_next;
        cnt   <= CW'(1);
        state <= SHIFT;
      end else begin
        case (state)
          SHIFT: begin
            sreg <= sreg_next;
            if (cnt == LAST_IDX) begin
              cnt   <= '0;
`ifdef PARITY_CHECK_EN
              state <= PAR;
`else
              state <= IDLE;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`ifdef PARITY_CHECK_EN
          PAR: begin
            cnt   <= '0;
            state <= IDLE;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  // Holding register and sticky overrun: a completed word replaces the held
  // one only if the slot is empty or being drained this cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (accept) begin
        data_out   <= word;
        data_valid <= 1'b1;
      end else if (transfer) begin
        data_valid <= 1'b0;
      end
      if (overrun_clr)                overrun <= 1'b0;
      else if (complete && !accept)   overrun <= 1'b1;
    end
  end

`ifdef PARITY_CHECK_EN
  // Sticky parity error; the word itself is still delivered.
  always_ff @(posedge clk) begin
    if (!rstn)                      parity_err <= 1'b0;
    else if (overrun_clr)           parity_err <= 1'b0;
    else if (complete && par_bad)   parity_err <= 1'b1;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
